block_generate_wb_burst_master: RTL and testbench



---
 rtl/block_test_pkg.sv | 34 +++
 rtl/block_test_pattern_gen.sv | 36 +++
 rtl/block_generate_wb_burst_master.sv | 189 ++++++++++++++++++
 tb/tb_block_generate_wb_burst_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_test_pkg.sv
// Shared definitions for the DS_DMA block-test Wishbone burst link:
// CTI/BTE codes, test-pattern selector encodings, burst-master FSM states
// and the pattern-word function.
package block_test_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] PAT_COUNT   = 2'b00;
    localparam logic [1:0] PAT_INVERT  = 2'b01;
    localparam logic [1:0] PAT_WALK    = 2'b10;
    localparam logic [1:0] PAT_PAIR    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP,
        ERR
    } wbm_state_e;

    // Test-pattern word for beat index n under selector sel.
    function automatic logic [63:0] pattern_word(input logic [63:0] n, input logic [1:0] sel);
        case (sel)
            PAT_COUNT:  pattern_word = n;
            PAT_INVERT: pattern_word = ~n;
            PAT_WALK:   pattern_word = 64'd1 << n[5:0];
            default:    pattern_word = {~n[31:0], n[31:0]};
        endcase
    endfunction

endpackage

// File: rtl/block_test_pattern_gen.sv
// Test-pattern generator: beat index counter that is cleared at enable and
// advanced on each completed beat, decoded to a 64-bit word by the selector.
module block_test_pattern_gen (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        clear_i,
    input  logic        advance_i,
    input  logic [1:0]  select_i,
    output logic [63:0] data_o
);
    import block_test_pkg::*;

    logic [63:0] n_q, n_d;

    // Next beat index: clear has priority over advance.
    always_comb begin
        n_d = n_q;
        if (clear_i) begin
            n_d = '0;
        end else if (advance_i) begin
            n_d = n_q + 64'd1;
        end
    end

    // Beat index register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            n_q <= '0;
        end else begin
            n_q <= n_d;
        end
    end

    assign data_o = pattern_word(n_q, select_i);

endmodule

// File: rtl/block_generate_wb_burst_master.sv
// Write-only Wishbone burst master generating fixed-length constant-address
// bursts of test-pattern data. Optional macro WBM_STALL_INJECT_EN drops STB
// for one cycle after every 8th completed beat.
module block_generate_wb_burst_master #(
    parameter int BURST_LEN  = 512,
    parameter int GAP_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [11:0] ov_wbm_burst_addr,
    output logic [63:0] ov_wbm_burst_data,
    output logic [7:0]  ov_wbm_burst_sel,
    output logic        o_wbm_burst_we,
    output logic        o_wbm_burst_cyc,
    output logic        o_wbm_burst_stb,
    output logic [2:0]  ov_wbm_burst_cti,
    output logic [1:0]  ov_wbm_burst_bte,
    input  logic        i_wbm_burst_ack,
    input  logic        i_wbm_burst_err,
    input  logic        i_wbm_burst_rty,
    input  logic [15:0] iv_control,
    output logic        o_busy,
    output logic        o_err_flag,
    output logic [15:0] ov_burst_count
);
    import block_test_pkg::*;

    localparam int            BW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST   = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_PENULT = BW'(BURST_LEN - 2);

    wbm_state_e    state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic [2:0]    cti_q, cti_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   gap_q, gap_d;
    logic [15:0]   count_q, count_d;
    logic          err_flag_q, err_flag_d;
    logic [1:0]    sel_q, sel_d;
    logic          en_prev_q;

    logic en_rise, wb_fault, beat_done, gap_last, pat_clear, pat_adv;
    logic unused_ctrl;

    assign en_rise   = iv_control[0] & ~en_prev_q;
    assign wb_fault  = cyc_q & (i_wbm_burst_err | i_wbm_burst_rty);
    assign beat_done = stb_q & i_wbm_burst_ack & ~wb_fault;
    assign gap_last  = (GAP_CYCLES <= 1) || (gap_q == 16'(GAP_CYCLES - 1));
    assign unused_ctrl = ^iv_control[15:4];

    // Next-state and registered-output decode for the burst FSM.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        cti_d      = cti_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        count_d    = count_q;
        err_flag_d = err_flag_q;
        sel_d      = sel_q;
        pat_clear  = 1'b0;
        pat_adv    = 1'b0;
        case (state_q)
            IDLE: begin
                cyc_d  = 1'b0;
                stb_d  = 1'b0;
                cti_d  = CTI_CLASSIC;
                beat_d = '0;
                gap_d  = '0;
                if (en_rise) begin
                    state_d    = BURST;
                    cyc_d      = 1'b1;
                    stb_d      = 1'b1;
                    cti_d      = CTI_CONST;
                    sel_d      = iv_control[3:2];
                    err_flag_d = 1'b0;
                    pat_clear  = 1'b1;
                end
            end
            BURST: begin
                if (wb_fault) begin
                    state_d    = ERR;
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    cti_d      = CTI_CLASSIC;
                    err_flag_d = 1'b1;
                end else if (beat_done) begin
                    pat_adv = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = GAP;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        cti_d   = CTI_CLASSIC;
                        beat_d  = '0;
                        gap_d   = '0;
                        count_d = count_q + 16'd1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        cti_d  = (beat_q == BEAT_PENULT) ? CTI_EOB : CTI_CONST;
`ifdef WBM_STALL_INJECT_EN
                        if ((32'(beat_q) & 32'd7) == 32'd7) begin
                            stb_d = 1'b0;
                        end
`endif
                    end
                end else begin
                    stb_d = 1'b1;
                end
            end
            GAP: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                if (gap_last) begin
                    gap_d = '0;
                    if (iv_control[1] && iv_control[0]) begin
                        state_d = BURST;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        cti_d   = CTI_CONST;
                        sel_d   = iv_control[3:2];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ERR: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                cti_d = CTI_CLASSIC;
                if (!iv_control[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered Wishbone outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            beat_q     <= '0;
            gap_q      <= '0;
            count_q    <= '0;
            err_flag_q <= 1'b0;
            sel_q      <= PAT_COUNT;
            en_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            cti_q      <= cti_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            count_q    <= count_d;
            err_flag_q <= err_flag_d;
            sel_q      <= sel_d;
            en_prev_q  <= iv_control[0];
        end
    end

    block_test_pattern_gen u_pattern (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .clear_i   (pat_clear),
        .advance_i (pat_adv),
        .select_i  (sel_q),
        .data_o    (ov_wbm_burst_data)
    );

    assign ov_wbm_burst_addr = '0;
    assign ov_wbm_burst_sel  = {8{cyc_q}};
    assign o_wbm_burst_we    = cyc_q;
    assign o_wbm_burst_cyc   = cyc_q;
    assign o_wbm_burst_stb   = stb_q;
    assign ov_wbm_burst_cti  = cti_q;
    assign ov_wbm_burst_bte  = BTE_LINEAR;
    assign o_busy            = (state_q != IDLE);
    assign o_err_flag        = err_flag_q;
    assign ov_burst_count    = count_q;

endmodule

// File: tb/tb_block_generate_wb_burst_master.sv
// Bench for block_generate_wb_burst_master: randomized slave wait states,
// error/retry injection and pattern selection, checked against a beat-index
// reference model of the test-pattern stream.
module tb_block_generate_wb_burst_master;

    localparam int BL  = 512;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        rty = 1'b0;
    logic [15:0] ctrl = 16'h0000;
    logic        busy, errf;
    logic [15:0] cnt;

    int unsigned     checks   = 0;
    int unsigned     failures = 0;
    longint unsigned model_n  = 0;

    block_generate_wb_burst_master #(
        .BURST_LEN  (BL),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .ov_wbm_burst_addr (addr),
        .ov_wbm_burst_data (data),
        .ov_wbm_burst_sel  (sel),
        .o_wbm_burst_we    (we),
        .o_wbm_burst_cyc   (cyc),
        .o_wbm_burst_stb   (stb),
        .ov_wbm_burst_cti  (cti),
        .ov_wbm_burst_bte  (bte),
        .i_wbm_burst_ack   (ack),
        .i_wbm_burst_err   (err),
        .i_wbm_burst_rty   (rty),
        .iv_control        (ctrl),
        .o_busy            (busy),
        .o_err_flag        (errf),
        .ov_burst_count    (cnt)
    );

    always #5 clk = ~clk;

    // Expected word for beat index n under pattern p.
    function automatic logic [63:0] exp_pat(input longint unsigned n, input logic [1:0] p);
        logic [63:0] v;
        v = 64'(n);
        case (p)
            2'd0:    return v;
            2'd1:    return ~v;
            2'd2:    return 64'd1 << (n % 64);
            default: return {~v[31:0], v[31:0]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"}, 64'(cyc), 64'd0);
        check({tag, "_stb"}, 64'(stb), 64'd0);
        check({tag, "_we"}, 64'(we), 64'd0);
        check({tag, "_sel"}, 64'(sel), 64'd0);
        check({tag, "_cti"}, 64'(cti), 64'd0);
        check({tag, "_data"}, data, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_errf"}, 64'(errf), 64'd0);
        check({tag, "_cnt"}, 64'(cnt), 64'd0);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_bte"}, 64'(bte), 64'd0);
    endtask

    // Serve one burst as the slave. Called at a negedge; returns at the
    // negedge following the last ack (or the injected err/rty).
    task automatic do_burst(input logic [1:0] pat, input bit rand_ack, input int err_beat,
                            input bit use_rty, input int chg_beat, input logic [15:0] chg_ctrl);
        int beat;
        int budget;
        bit done;
        logic [2:0] exp_cti;
        beat   = 0;
        done   = 1'b0;
        budget = 0;
        while (!cyc && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("burst_start_cyc", 64'(cyc), 64'd1);
        budget = 0;
        while (!done && budget < 20000) begin
            if (stb) begin
                exp_cti = (beat == BL - 1) ? 3'b111 : 3'b001;
                check("beat_data", data, exp_pat(model_n, pat));
                check("beat_cti", 64'(cti), 64'(exp_cti));
                check("beat_sel", 64'(sel), 64'hFF);
                check("beat_we", 64'(we), 64'd1);
                if (beat == err_beat) begin
                    ack = 1'b0;
                    if (use_rty) rty = 1'b1;
                    else         err = 1'b1;
                    done = 1'b1;
                end else if (!rand_ack || $urandom_range(0, 2) != 0) begin
                    ack = 1'b1;
                    if (beat == chg_beat) ctrl = chg_ctrl;
                    beat++;
                    model_n++;
                    if (beat == BL) done = 1'b1;
                end else begin
                    ack = 1'b0;
                end
            end else begin
                ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            budget++;
            ack = 1'b0;
            err = 1'b0;
            rty = 1'b0;
        end
        check("burst_done_in_budget", 64'(done), 64'd1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("wait_idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        ctrl = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int gapn;
        bit saw_cyc;

        // Power-on reset state
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single burst, pattern 00, ack every cycle
        ctrl = 16'h0001;
        model_n = 0;
        do_burst(2'd0, 1'b0, -1, 1'b0, -1, 16'h0001);
        check("single_cyc_drop", 64'(cyc), 64'd0);
        check("single_count", 64'(cnt), 64'd1);
        saw_cyc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cyc) saw_cyc = 1'b1;
        end
        check("single_no_extra_burst", 64'(saw_cyc), 64'd0);
        check("single_busy_low", 64'(busy), 64'd0);

        // Continuous with random wait states, gap length, mid-burst disable
        do_reset();
        ctrl = 16'h0003;
        model_n = 0;
        do_burst(2'd0, 1'b1, -1, 1'b0, -1, 16'h0003);
        check("cont_count1", 64'(cnt), 64'd1);
        gapn = 0;
        while (!cyc && gapn < 100) begin
            gapn++;
            @(negedge clk);
        end
        check("cont_gap_len", 64'(gapn), 64'(GAP));
        do_burst(2'd0, 1'b1, -1, 1'b0, -1, 16'h0003);
        check("cont_count2", 64'(cnt), 64'd2);
        do_burst(2'd0, 1'b1, -1, 1'b0, 10, 16'h0002);
        check("disable_count3", 64'(cnt), 64'd3);
        saw_cyc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cyc) saw_cyc = 1'b1;
        end
        check("disable_no_burst", 64'(saw_cyc), 64'd0);
        check("disable_busy_low", 64'(busy), 64'd0);

        // err on beat 100
        do_reset();
        ctrl = 16'h0003;
        model_n = 0;
        do_burst(2'd0, 1'b1, 100, 1'b0, -1, 16'h0003);
        check("err_cyc_drop", 64'(cyc), 64'd0);
        check("err_flag_set", 64'(errf), 64'd1);
        check("err_count", 64'(cnt), 64'd0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("err_hold_cyc", 64'(cyc), 64'd0);
        check("err_hold_busy", 64'(busy), 64'd1);
        ctrl = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check("err_exit_busy", 64'(busy), 64'd0);
        check("err_flag_sticky", 64'(errf), 64'd1);
        // Restart clears the flag and the pattern; rty on the last beat
        ctrl = 16'h0001;
        model_n = 0;
        @(negedge clk);
        check("restart_flag_clear", 64'(errf), 64'd0);
        do_burst(2'd0, 1'b1, BL - 1, 1'b1, -1, 16'h0001);
        check("rty_last_count", 64'(cnt), 64'd0);
        check("rty_last_flag", 64'(errf), 64'd1);
        check("rty_last_cyc", 64'(cyc), 64'd0);
        ctrl = 16'h0000;
        wait_idle();

        // Patterns: 10 then 11 (select changed mid-burst), then 01
        do_reset();
        ctrl = 16'h000B;
        model_n = 0;
        do_burst(2'd2, 1'b1, -1, 1'b0, 300, 16'h000F);
        do_burst(2'd3, 1'b1, -1, 1'b0, 5, 16'h0005);
        wait_idle();
        ctrl = 16'h0000;
        @(negedge clk);
        ctrl = 16'h0005;
        model_n = 0;
        do_burst(2'd1, 1'b1, -1, 1'b0, -1, 16'h0005);
        check("pattern_count", 64'(cnt), 64'd3);
        wait_idle();

        // Asynchronous reset in the middle of a burst
        ctrl = 16'h0000;
        @(negedge clk);
        ctrl = 16'h0003;
        ack = 1'b1;
        for (int i = 0; i < 40; i++) @(negedge clk);
        check("pre_reset_cyc", 64'(cyc), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        ack = 1'b0;
        ctrl = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
